// File: rtl/cordic_scheduler.sv
// Round-robin front end that shares one iterative CORDIC sin/cos core among
// N_REQ requesters and returns each result tagged with its requester index.
module cordic_scheduler #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned CORE_LAT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_angle,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_sin,
    output logic [31:0]           resp_cos,
    output logic                  busy,
    output logic                  core_start,
    output logic [31:0]           core_angle,
    input  logic [31:0]           core_sin,
    input  logic [31:0]           core_cos
);

    localparam int unsigned CNT_W = $clog2(CORE_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]    job_id, job_id_nxt;
    logic [31:0]        core_angle_nxt;
    logic [31:0]        resp_sin_nxt, resp_cos_nxt;
    logic [ID_W-1:0]    resp_id_nxt;
    logic               resp_valid_nxt;

    logic [2*N_REQ-1:0] rr_dbl;
    logic [ID_W:0]      scan_sum;
    logic               grant_found;
    logic [ID_W-1:0]    grant;
    logic [31:0]        angle_sel;

    // Round-robin search: first valid requester at or after rr_ptr, modulo N_REQ.
    always_comb begin
        rr_dbl      = {req_valid, req_valid} >> rr_ptr;
        grant_found = 1'b0;
        grant       = '0;
        scan_sum    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && rr_dbl[i]) begin
                grant_found = 1'b1;
                scan_sum    = {1'b0, rr_ptr} + (ID_W+1)'(i);
                if (scan_sum >= (ID_W+1)'(N_REQ)) begin
                    scan_sum = scan_sum - (ID_W+1)'(N_REQ);
                end
                grant = scan_sum[ID_W-1:0];
            end
        end
    end

    // Angle slice of the granted requester.
    always_comb begin
        angle_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant == ID_W'(k)) begin
                angle_sel = req_angle[k*32 +: 32];
            end
        end
    end

    // Acceptance strobe is only offered from IDLE and never while in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready = N_REQ'(1) << grant;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        cnt_nxt        = cnt;
        job_id_nxt     = job_id;
        core_angle_nxt = core_angle;
        resp_sin_nxt   = resp_sin;
        resp_cos_nxt   = resp_cos;
        resp_id_nxt    = resp_id;
        resp_valid_nxt = resp_valid;

        case (state)
            IDLE: begin
                if (grant_found) begin
                    core_angle_nxt = angle_sel;
                    job_id_nxt     = grant;
                    if (grant == ID_W'(N_REQ-1)) begin
                        rr_ptr_nxt = '0;
                    end else begin
                        rr_ptr_nxt = grant + ID_W'(1);
                    end
                    state_nxt = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = RUN;
            end
            RUN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(CORE_LAT-1)) begin
                    resp_sin_nxt   = core_sin;
                    resp_cos_nxt   = core_cos;
                    resp_id_nxt    = job_id;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            job_id     <= '0;
            core_angle <= '0;
            resp_sin   <= '0;
            resp_cos   <= '0;
            resp_id    <= '0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            cnt        <= cnt_nxt;
            job_id     <= job_id_nxt;
            core_angle <= core_angle_nxt;
            resp_sin   <= resp_sin_nxt;
            resp_cos   <= resp_cos_nxt;
            resp_id    <= resp_id_nxt;
            resp_valid <= resp_valid_nxt;
        end
    end

    // Status strobes decoded straight from the state register.
    assign busy       = (state != IDLE);
    assign core_start = (state == START);

endmodule

// File: doc/cordic_scheduler.md
Name: cordic_scheduler

Overview:
Shares one iterative CORDIC sin/cos core among N_REQ requesters using round-robin arbitration.
Accepts an angle (IEEE-754 single) from the granted requester and pulses the core's start.
Holds the core's angle input stable for the whole computation, counts the core's fixed iteration latency, captures sin/cos and returns them with the requester index over a valid/ready response channel.
Sits between client blocks and the single cordic core instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of resp_id; must be >= clog2(N_REQ)
CORE_LAT, 16, cycles from the cycle after core_start to the cycle in which the core outputs are valid (core's i reaches 15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  N_REQ  per-requester request valid; must hold until accepted
req_angle  in  32*N_REQ  per-requester angle, slice k = bits [32k+31:32k], IEEE-754 radians
req_ready  out  N_REQ  one-hot acceptance strobe
resp_valid  out  1  result valid, held until resp_ready
resp_ready  in  1  consumer accepts result
resp_id  out  ID_W  index of the requester that owns the result
resp_sin  out  32  captured core sin
resp_cos  out  32  captured core cos
busy  out  1  high in any state other than IDLE
core_start  out  1  to core start
core_angle  out  32  to core angle; stable from START through the capture cycle
core_sin  in  32  from core
core_cos  in  32  from core

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, rr_ptr=0, cnt=0.
  - core_angle=0, resp_sin=resp_cos=0, resp_id=0.
  - resp_valid=0, core_start=0, busy=0, req_ready=0.
- Reset mid-operation aborts the job silently. The core is not drained; the next START re-initialises it.
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - Grant = first k with req_valid[k]=1, searching k = rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[grant]=1 combinationally in the same cycle; all other bits 0; req_ready is 0 in every other state.
  - On that edge: latch req_angle[grant] into core_angle, latch grant into the job id, set rr_ptr = (grant+1) mod N_REQ, go to START.
  - With no req_valid: stay in IDLE, rr_ptr unchanged.
- START: core_start=1 for exactly this one cycle; cnt<=0; go to RUN.
- RUN:
  - cnt increments each cycle.
  - In the RUN cycle with cnt=CORE_LAT-1 (the CORE_LAT-th RUN cycle): register core_sin into resp_sin, core_cos into resp_cos, and the job id into resp_id; set resp_valid; go to DONE.
- DONE:
  - resp_valid=1; resp_sin, resp_cos and resp_id are held stable.
  - On resp_valid & resp_ready: clear resp_valid and go to IDLE.
  - New requests wait; there is no back-to-back overlap.
- Latency:
  - Accept edge at the end of cycle A.
  - core_start is high in cycle A+1.
  - Capture occurs at the end of cycle A+1+CORE_LAT.
  - resp_valid rises in cycle A+2+CORE_LAT (A+18 at default).
  - Minimum period per job is CORE_LAT+3 cycles (19 at default).
- Boundary behaviour:
  - core_angle never changes between the accept edge and leaving RUN, because the core's quadrant select is combinational on angle.
  - A requester dropping req_valid before acceptance is legal; it is simply not granted.
  - All requesters valid continuously are served in order rr_ptr, rr_ptr+1, ... with no starvation.
  - rr_ptr wraps from N_REQ-1 to 0.
  - resp_ready held high in DONE completes in one cycle; resp_ready high outside DONE is ignored.
- Arithmetic: cnt is clog2(CORE_LAT)+1 bits wide; no float arithmetic in this block.

Test Plan:
- Core stub behaviour used by all tests:
  - Internal counter loads 0 on start and increments every cycle.
  - core_sin=core_angle and core_cos=~core_angle only while the counter is 15; both are 0 otherwise.
  - The stub flags any change of core_angle between start and capture.
- Single job: req_valid[2]=1, angle=0x3F490FDB at cycle 0 -> req_ready=0b0100 in cycle 0, core_start in cycle 1 only, resp_valid in cycle 18 with resp_id=2, resp_sin=0x3F490FDB, resp_cos=0xC0B6F024.
- Round-robin: all four requesters valid continuously with angles 0x3F800000+k, resp_ready=1 -> grants 0,1,2,3,0 at 19-cycle spacing; each resp_id matches its angle.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_* stable, busy=1, no req_ready pulse; resp_ready=1 -> IDLE the next cycle.
- Pointer wrap: rr_ptr=3 after granting 2, then req_valid=0b1001 -> requester 3 granted first, then 0.
- Reset mid-RUN: rst_n=0 for one edge at RUN cnt=7 -> all outputs at reset values the next cycle, no resp_valid; a new request completes normally with correct data.
